// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter_if
// Description : I-cache, D-cache and burst-memory signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [LEN_W-1:0]  inst_len;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_done;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [LEN_W-1:0]  data_len;
    logic [3:0]        data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              data_wready;
    logic              data_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wvalid;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wlast;
    logic              mem_wready;
    logic              mem_bvalid;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr, inst_len,
        output inst_gnt, inst_rvalid, inst_rdata, inst_done,
        input  data_req, data_we, data_addr, data_len, data_wstrb, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_wready, data_done,
        output mem_req, mem_we, mem_addr, mem_len, mem_wstrb,
        input  mem_ack, mem_rvalid, mem_rdata,
        output mem_wvalid, mem_wdata, mem_wlast,
        input  mem_wready, mem_bvalid
    );

    // Caches and memory side
    modport master (
        output inst_req, inst_addr, inst_len,
        input  inst_gnt, inst_rvalid, inst_rdata, inst_done,
        output data_req, data_we, data_addr, data_len, data_wstrb, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_wready, data_done,
        input  mem_req, mem_we, mem_addr, mem_len, mem_wstrb,
        output mem_ack, mem_rvalid, mem_rdata,
        input  mem_wvalid, mem_wdata, mem_wlast,
        output mem_wready, mem_bvalid
    );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one burst memory port between I-cache and D-cache,
//               data-priority with a starvation override for instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input wire                 clk,
    input wire                 rst,
    cache_mem_arbiter_if.slave bus
);
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WRESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    state_t                  r_state, w_next_state;
    owner_t                  r_owner;
    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_len;
    logic [3:0]              r_wstrb;
    logic [LEN_W-1:0]        r_beat_cnt;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic                    r_inst_gnt, r_data_gnt;

    logic                    w_starved, w_last;
    logic                    w_grant_inst, w_grant_data;
    logic                    w_beat_clr, w_beat_inc, w_burst_done;
    logic                    w_inst_rvalid, w_inst_done;
    logic [DATA_W-1:0]       w_inst_rdata;
    logic                    w_data_rvalid, w_data_wready, w_data_done;
    logic [DATA_W-1:0]       w_data_rdata;
    logic                    w_mem_req, w_mem_wvalid, w_mem_wlast;
    logic [DATA_W-1:0]       w_mem_wdata;

    assign w_starved = bus.inst_req && (r_starve_cnt == c_STARVE_MAX);
    assign w_last    = (r_beat_cnt == r_len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_inst  = 1'b0;
        w_grant_data  = 1'b0;
        w_beat_clr    = 1'b0;
        w_beat_inc    = 1'b0;
        w_burst_done  = 1'b0;
        w_inst_rvalid = 1'b0;
        w_inst_rdata  = '0;
        w_inst_done   = 1'b0;
        w_data_rvalid = 1'b0;
        w_data_rdata  = '0;
        w_data_wready = 1'b0;
        w_data_done   = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_wvalid  = 1'b0;
        w_mem_wdata   = '0;
        w_mem_wlast   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.data_req && !w_starved) begin
                    w_grant_data = 1'b1;
                    w_next_state = ADDR;
                end else if (bus.inst_req) begin
                    w_grant_inst = 1'b1;
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_beat_clr   = 1'b1;
                    w_next_state = r_we ? WDATA : RDATA;
                end
            end
            RDATA: begin
                if (r_owner == OWN_INST) begin
                    w_inst_rvalid = bus.mem_rvalid;
                    w_inst_rdata  = bus.mem_rdata;
                    w_inst_done   = bus.mem_rvalid && w_last;
                end else if (r_owner == OWN_DATA) begin
                    w_data_rvalid = bus.mem_rvalid;
                    w_data_rdata  = bus.mem_rdata;
                    w_data_done   = bus.mem_rvalid && w_last;
                end
                if (bus.mem_rvalid) begin
                    w_beat_inc = 1'b1;
                    if (w_last) begin
                        w_burst_done = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            WDATA: begin
                w_mem_wvalid  = 1'b1;
                w_mem_wdata   = bus.data_wdata;
                w_mem_wlast   = w_last;
                w_data_wready = bus.mem_wready;
                if (bus.mem_wready) begin
                    w_beat_inc = 1'b1;
                    if (w_last) w_next_state = WRESP;
                end
            end
            WRESP: begin
                if (bus.mem_bvalid) begin
                    w_data_done  = 1'b1;
                    w_burst_done = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner      <= OWN_NONE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_wstrb      <= '0;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
            r_inst_gnt   <= 1'b0;
            r_data_gnt   <= 1'b0;
        end else begin
            r_inst_gnt <= w_grant_inst;
            r_data_gnt <= w_grant_data;
            if (w_grant_data) begin
                r_owner <= OWN_DATA;
                r_we    <= bus.data_we;
                r_addr  <= bus.data_addr;
                r_len   <= bus.data_len;
                r_wstrb <= bus.data_wstrb;
                // Only grants that bypass a waiting instruction count toward starvation
                if (!bus.inst_req) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
                end
            end else if (w_grant_inst) begin
                r_owner      <= OWN_INST;
                r_we         <= 1'b0;
                r_addr       <= bus.inst_addr;
                r_len        <= bus.inst_len;
                r_wstrb      <= 4'h0;
                r_starve_cnt <= '0;
            end else if (w_burst_done) begin
                r_owner <= OWN_NONE;
            end
            if (w_beat_clr) begin
                r_beat_cnt <= '0;
            end else if (w_beat_inc) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    assign bus.inst_gnt    = r_inst_gnt;
    assign bus.inst_rvalid = w_inst_rvalid;
    assign bus.inst_rdata  = w_inst_rdata;
    assign bus.inst_done   = w_inst_done;
    assign bus.data_gnt    = r_data_gnt;
    assign bus.data_rvalid = w_data_rvalid;
    assign bus.data_rdata  = w_data_rdata;
    assign bus.data_wready = w_data_wready;
    assign bus.data_done   = w_data_done;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = r_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_len     = r_len;
    assign bus.mem_wstrb   = r_wstrb;
    assign bus.mem_wvalid  = w_mem_wvalid;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_wlast   = w_mem_wlast;
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 4;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] grant_order [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    cache_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first address-phase cycle; returns in the idle cycle after done
    task automatic run_read(input int beats);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        repeat (beats) cyc();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        bus.inst_req   = 1'b0; bus.inst_addr = '0; bus.inst_len = '0;
        bus.data_req   = 1'b0; bus.data_we   = 1'b0; bus.data_addr = '0;
        bus.data_len   = '0;   bus.data_wstrb = '0;  bus.data_wdata = '0;
        bus.mem_ack    = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.mem_wready = 1'b0; bus.mem_bvalid = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_inst_gnt", 64'(bus.inst_gnt), 64'd0);
        chk("rst_data_gnt", 64'(bus.data_gnt), 64'd0);
        chk("rst_mem_req",  64'(bus.mem_req),  64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        rst = 1'b1;
        cyc();

        // Instruction burst, len=3
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1FC0_0000;
        bus.inst_len  = 4'd3;
        settle();
        chk("i_gnt_before_edge", 64'(bus.inst_gnt), 64'd0);
        cyc();
        chk("i_gnt_n1",    64'(bus.inst_gnt), 64'd1);
        chk("i_mem_req",   64'(bus.mem_req),  64'd1);
        chk("i_mem_addr",  64'(bus.mem_addr), 64'h1FC0_0000);
        chk("i_mem_len",   64'(bus.mem_len),  64'd3);
        chk("i_mem_we",    64'(bus.mem_we),   64'd0);
        bus.inst_req = 1'b0;
        bus.mem_ack  = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("i_gnt_pulse", 64'(bus.inst_gnt), 64'd0);
        chk("i_req_drop",  64'(bus.mem_req),  64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hA000_0000 + i;
            settle();
            chk("i_rvalid", 64'(bus.inst_rvalid), 64'd1);
            chk("i_rdata",  64'(bus.inst_rdata),  64'hA000_0000 + 64'(i));
            chk("i_done",   64'(bus.inst_done),   (i == 3) ? 64'd1 : 64'd0);
            chk("i_d_rvalid", 64'(bus.data_rvalid), 64'd0);
            cyc();
        end
        settle();
        chk("idle_spurious_rvalid", 64'(bus.inst_rvalid), 64'd0);
        bus.mem_rvalid = 1'b0;

        // Simultaneous requests: data first, inst after data_done
        bus.data_req  = 1'b1; bus.data_we = 1'b0;
        bus.data_addr = 32'h8000_0010; bus.data_len = 4'd0;
        bus.inst_req  = 1'b1; bus.inst_addr = 32'h0000_1000; bus.inst_len = 4'd0;
        cyc();
        chk("both_data_gnt", 64'(bus.data_gnt), 64'd1);
        chk("both_inst_gnt", 64'(bus.inst_gnt), 64'd0);
        chk("both_mem_addr", 64'(bus.mem_addr), 64'h8000_0010);
        bus.data_req   = 1'b0;
        bus.mem_rvalid = 1'b1;
        settle();
        chk("addr_spurious_d", 64'(bus.data_rvalid), 64'd0);
        chk("addr_spurious_i", 64'(bus.inst_rvalid), 64'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        bus.mem_ack    = 1'b1;
        settle();
        chk("addr_hold_req", 64'(bus.mem_req), 64'd1);
        cyc();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        settle();
        chk("d_rvalid", 64'(bus.data_rvalid), 64'd1);
        chk("d_rdata",  64'(bus.data_rdata),  64'hDEAD_BEEF);
        chk("d_done",   64'(bus.data_done),   64'd1);
        chk("d_i_rvalid", 64'(bus.inst_rvalid), 64'd0);
        cyc();
        bus.mem_rvalid = 1'b0;
        settle();
        chk("gap_inst_gnt", 64'(bus.inst_gnt), 64'd0);
        chk("gap_mem_req",  64'(bus.mem_req),  64'd0);
        cyc();
        chk("after_d_inst_gnt", 64'(bus.inst_gnt), 64'd1);
        chk("after_d_mem_addr", 64'(bus.mem_addr), 64'h0000_1000);
        bus.inst_req = 1'b0;
        run_read(1);

        // Starvation: both held -> D,D,D,D,I,D
        bus.data_req = 1'b1;
        bus.inst_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            cyc();
            chk("starve_order", 64'({bus.inst_gnt, bus.data_gnt}), 64'(grant_order[g]));
            if (g == 5) begin
                bus.data_req = 1'b0;
                bus.inst_req = 1'b0;
            end
            run_read(1);
        end

        // Data write, len=1, wready low two cycles
        bus.data_req   = 1'b1; bus.data_we = 1'b1;
        bus.data_addr  = 32'h0000_2000; bus.data_len = 4'd1;
        bus.data_wstrb = 4'hF; bus.data_wdata = 32'h1111_0000;
        cyc();
        chk("w_gnt",   64'(bus.data_gnt),  64'd1);
        chk("w_we",    64'(bus.mem_we),    64'd1);
        chk("w_wstrb", 64'(bus.mem_wstrb), 64'hF);
        chk("w_len",   64'(bus.mem_len),   64'd1);
        bus.data_req  = 1'b0;
        bus.data_addr = 32'hFFFF_FFFF;
        bus.mem_ack   = 1'b1;
        settle();
        chk("w_addr_latched", 64'(bus.mem_addr), 64'h0000_2000);
        cyc();
        bus.mem_ack    = 1'b0;
        bus.mem_wready = 1'b0;
        settle();
        chk("w_wvalid_b0", 64'(bus.mem_wvalid),  64'd1);
        chk("w_wlast_b0",  64'(bus.mem_wlast),   64'd0);
        chk("w_wready_lo", 64'(bus.data_wready), 64'd0);
        chk("w_wdata_b0",  64'(bus.mem_wdata),   64'h1111_0000);
        cyc();
        cyc();
        bus.mem_wready = 1'b1;
        settle();
        chk("w_wready_b0", 64'(bus.data_wready), 64'd1);
        chk("w_wlast_b0b", 64'(bus.mem_wlast),   64'd0);
        cyc();
        bus.data_wdata = 32'h1111_0001;
        settle();
        chk("w_wlast_b1",  64'(bus.mem_wlast),   64'd1);
        chk("w_wdata_b1",  64'(bus.mem_wdata),   64'h1111_0001);
        chk("w_wready_b1", 64'(bus.data_wready), 64'd1);
        cyc();
        settle();
        chk("wresp_wvalid", 64'(bus.mem_wvalid),  64'd0);
        chk("wresp_wready", 64'(bus.data_wready), 64'd0);
        chk("wresp_nodone", 64'(bus.data_done),   64'd0);
        bus.mem_wready = 1'b0;
        cyc();
        bus.mem_bvalid = 1'b1;
        settle();
        chk("w_done", 64'(bus.data_done), 64'd1);
        cyc();
        settle();
        chk("idle_spurious_bvalid", 64'(bus.data_done), 64'd0);
        bus.mem_bvalid = 1'b0;

        // Reset mid-RDATA at beat 2 of 8
        bus.data_req  = 1'b1; bus.data_we = 1'b0;
        bus.data_addr = 32'h0000_3000; bus.data_len = 4'd7;
        bus.inst_req  = 1'b1;
        cyc();
        chk("r8_gnt", 64'(bus.data_gnt), 64'd1);
        bus.data_req = 1'b0;
        bus.inst_req = 1'b0;
        bus.mem_ack  = 1'b1;
        cyc();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        chk("r8_beat2_rvalid", 64'(bus.data_rvalid), 64'd1);
        cyc();
        rst = 1'b1;
        settle();
        chk("post_rst_rvalid", 64'(bus.data_rvalid), 64'd0);
        chk("post_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("post_rst_mem_len",  64'(bus.mem_len),  64'd0);
        chk("post_rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("post_rst_state",  64'(dut.r_state),      64'd0);
        chk("post_rst_starve", 64'(dut.r_starve_cnt), 64'd0);
        bus.mem_rvalid = 1'b0;

        // Longest burst: len=15 completes on beat 16 without wrap
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_4000; bus.data_len = 4'd15;
        cyc();
        chk("l15_gnt", 64'(bus.data_gnt), 64'd1);
        bus.data_req = 1'b0;
        bus.mem_ack  = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'(i);
            settle();
            chk("l15_done", 64'(bus.data_done), (i == 15) ? 64'd1 : 64'd0);
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        settle();
        chk("l15_idle", 64'(dut.r_state), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
